// File: rtl/dac_update_sched_pkg.sv
// rtl/dac_update_sched_pkg.sv - shared types and constants for the DAC update scheduler
package dac_sched_pkg;

    localparam int DAC_W_DEFAULT = 10;
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SLEW   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dac_update_sched_if.sv
// rtl/dac_update_sched_if.sv - two-requester valid/ready code update bundle
interface dac_update_sched_if
    import dac_sched_pkg::*;
#(
    parameter int DAC_W = DAC_W_DEFAULT
) ();

    logic             req0_valid;
    logic [DAC_W-1:0] req0_code;
    logic             req0_ready;
    logic             req1_valid;
    logic [DAC_W-1:0] req1_code;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_code, req1_valid, req1_code,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_code, req1_valid, req1_code,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/dac_update_sched_rr_arb2.sv
// rtl/dac_update_sched_rr_arb2.sv - combinational 2-way round-robin grant
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid0 && (!valid1 || last_grant);
        grant[1] = valid1 && (!valid0 || !last_grant);
    end

endmodule

// File: rtl/dac_update_sched.sv
// rtl/dac_update_sched.sv - arbitrated DAC code updater with settle hold; optional slew limit via DAC_SLEW_LIMIT_EN
module dac_update_sched
    import dac_sched_pkg::*;
#(
    parameter int DAC_W         = DAC_W_DEFAULT,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESET_CODE    = 0,
    parameter int MAX_STEP      = 64
) (
    input  logic                 CLK,
    input  logic                 reset,
    dac_update_sched_if.slave    req,
    output logic [DAC_W-1:0]     dac_code,
    output logic                 upd_pulse,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DAC_W-1:0] RESET_VAL   = DAC_W'(RESET_CODE);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || MAX_STEP < 1) begin : g_bad_param
        $error("dac_update_sched: SETTLE_CYCLES or MAX_STEP out of range");
    end

    sched_state_e     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [DAC_W-1:0] code_next;
    logic             pulse_next;
    logic             last_grant, lg_next;
    logic [1:0]       grant;
    logic             xfer0, xfer1, xfer;
    logic [DAC_W-1:0] grant_code;

    rr_arb2 u_arb (
        .valid0     (req.req0_valid),
        .valid1     (req.req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Gating with reset keeps both readies low while reset is held, even though state is already IDLE.
    assign req.req0_ready = (state == IDLE) && !reset && grant[0];
    assign req.req1_ready = (state == IDLE) && !reset && grant[1];

    assign xfer0      = req.req0_valid && req.req0_ready;
    assign xfer1      = req.req1_valid && req.req1_ready;
    assign xfer       = xfer0 || xfer1;
    assign grant_code = xfer1 ? req.req1_code : req.req0_code;

`ifdef DAC_SLEW_LIMIT_EN
    localparam logic [DAC_W:0] MAX_STEP_W = (DAC_W + 1)'(MAX_STEP);

    logic [DAC_W-1:0] target, target_next;

    function automatic logic [DAC_W-1:0] slew_step(input logic [DAC_W-1:0] cur,
                                                   input logic [DAC_W-1:0] tgt);
        logic [DAC_W:0] cur_w, tgt_w, diff, stp, res;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        diff  = (tgt_w >= cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);
        stp   = (diff > MAX_STEP_W) ? MAX_STEP_W : diff;
        res   = (tgt_w >= cur_w) ? (cur_w + stp) : (cur_w - stp);
        return res[DAC_W-1:0];
    endfunction
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = dac_code;
        pulse_next = 1'b0;
        lg_next    = last_grant;
`ifdef DAC_SLEW_LIMIT_EN
        target_next = target;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    lg_next    = xfer1;
                    cnt_next   = SETTLE_INIT;
                    pulse_next = 1'b1;
                    state_next = SETTLE;
`ifdef DAC_SLEW_LIMIT_EN
                    target_next = grant_code;
                    code_next   = slew_step(dac_code, grant_code);
`else
                    code_next   = grant_code;
`endif
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
`ifdef DAC_SLEW_LIMIT_EN
                    state_next = (dac_code != target) ? SLEW : IDLE;
`else
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
`ifdef DAC_SLEW_LIMIT_EN
            SLEW: begin
                code_next  = slew_step(dac_code, target);
                pulse_next = 1'b1;
                cnt_next   = SETTLE_INIT;
                state_next = SETTLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dac_code   <= RESET_VAL;
            upd_pulse  <= 1'b0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
`ifdef DAC_SLEW_LIMIT_EN
            target     <= RESET_VAL;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            dac_code   <= code_next;
            upd_pulse  <= pulse_next;
            busy       <= (state_next != IDLE);
            last_grant <= lg_next;
`ifdef DAC_SLEW_LIMIT_EN
            target     <= target_next;
`endif
        end
    end

endmodule
